// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit map, default widths and stage payload layout
// for the inter-stage pipeline buffers.
package pipe_pkg;

    localparam int CTRL_REGWRT   = 0;
    localparam int CTRL_BRANCH   = 1;
    localparam int CTRL_BTYPE    = 2;
    localparam int CTRL_JUMP     = 3;
    localparam int CTRL_MEMTOREG = 4;
    localparam int CTRL_NEG      = 5;
    localparam int CTRL_ZERO     = 6;

    localparam int CTRL_W_DEF = 7;
    localparam int DATA_W_DEF = 32;
    localparam int RD_W_DEF   = 6;

    typedef struct packed {
        logic                  valid;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] memdata;
        logic [DATA_W_DEF-1:0] aluresult;
        logic [RD_W_DEF-1:0]   rd;
    } stage_t;

    // A squashed slot keeps its data but can never carry live control.
    function automatic stage_t bubble(input stage_t s);
        stage_t b;
        b       = s;
        b.valid = 1'b0;
        b.ctrl  = '0;
        return b;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one payload stage of the pipeline buffer with
// async active-low reset, flush (bubble) and stall (hold).
module pipe_stage_reg #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 32,
    parameter int RD_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_memdata,
    output logic [DATA_W-1:0] out_aluresult,
    output logic [RD_W-1:0]   out_rd
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_ctrl      <= '0;
            out_memdata   <= '0;
            out_aluresult <= '0;
            out_rd        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (!stall) begin
            out_valid     <= in_valid;
            out_ctrl      <= in_ctrl;
            out_memdata   <= in_memdata;
            out_aluresult <= in_aluresult;
            out_rd        <= in_rd;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer: DEPTH-stage inter-stage buffer with valid, stall, flush and
// falling- or rising-edge output release. PIPE_STAGE_BUFFER_STATS_EN adds stall/flush counters.
module pipe_stage_buffer
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int CTRL_W      = CTRL_W_DEF,
    parameter int RD_W        = RD_W_DEF,
    parameter int DEPTH       = 1,
    parameter bit NEG_RELEASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_memdata,
    input  logic [DATA_W-1:0] in_aluresult,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_memdata,
    output logic [DATA_W-1:0] out_aluresult,
    output logic [RD_W-1:0]   out_rd
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
`endif
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_buffer: DEPTH must be in 1..4");
        end
    endgenerate

    // Index 0 is the input side; index k is the output of stage k-1.
    logic              valid_c     [DEPTH+1];
    logic [CTRL_W-1:0] ctrl_c      [DEPTH+1];
    logic [DATA_W-1:0] memdata_c   [DEPTH+1];
    logic [DATA_W-1:0] aluresult_c [DEPTH+1];
    logic [RD_W-1:0]   rd_c        [DEPTH+1];

    assign valid_c[0]     = in_valid;
    assign ctrl_c[0]      = in_ctrl;
    assign memdata_c[0]   = in_memdata;
    assign aluresult_c[0] = in_aluresult;
    assign rd_c[0]        = in_rd;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            pipe_stage_reg #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .RD_W   (RD_W)
            ) u_stage (
                .clk           (clk),
                .rst_n         (rst_n),
                .stall         (stall),
                .flush         (flush),
                .in_valid      (valid_c[i]),
                .in_ctrl       (ctrl_c[i]),
                .in_memdata    (memdata_c[i]),
                .in_aluresult  (aluresult_c[i]),
                .in_rd         (rd_c[i]),
                .out_valid     (valid_c[i+1]),
                .out_ctrl      (ctrl_c[i+1]),
                .out_memdata   (memdata_c[i+1]),
                .out_aluresult (aluresult_c[i+1]),
                .out_rd        (rd_c[i+1])
            );
        end
    endgenerate

    // Control is qualified by valid so a bubble never drives regwrt/branch/jump.
    logic [CTRL_W-1:0] ctrl_m;
    assign ctrl_m = ctrl_c[DEPTH] & {CTRL_W{valid_c[DEPTH]}};

    generate
        if (NEG_RELEASE) begin : g_neg
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid     <= 1'b0;
                    out_ctrl      <= '0;
                    out_memdata   <= '0;
                    out_aluresult <= '0;
                    out_rd        <= '0;
                end else begin
                    out_valid     <= valid_c[DEPTH];
                    out_ctrl      <= ctrl_m;
                    out_memdata   <= memdata_c[DEPTH];
                    out_aluresult <= aluresult_c[DEPTH];
                    out_rd        <= rd_c[DEPTH];
                end
            end
        end else begin : g_pos
            assign out_valid     = valid_c[DEPTH];
            assign out_ctrl      = ctrl_m;
            assign out_memdata   = memdata_c[DEPTH];
            assign out_aluresult = aluresult_c[DEPTH];
            assign out_rd        = rd_c[DEPTH];
        end
    endgenerate

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    // Counters saturate so long stalls never wrap back to small values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule
